load_store_unit: RTL and testbench

- Initiator side of the core's data-memory port. Accepts byte-addressed load/store requests from the execute stage, using RV32 funct3 encoding.
- Drives the word-addressed, byte-enabled data memory: combinational read, write on posedge.
- Splits misaligned accesses that cross a word boundary into two word accesses, then aligns, merges and sign/zero-extends load data.
- Returns the result to the core through a valid/ready response handshake.

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed RV32 requests to a word-addressed,
// byte-enabled data memory, with word-crossing split and load extension.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [2:0]            mem_op_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] wa0_q, wa0_d;
  logic                  cross_q, cross_d;
  logic                  we_q, we_d;
  logic [7:0]            be8_q, be8_d;
  logic [63:0]           wd64_q, wd64_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [2:0]  nb;
  logic [2:0]  span;
  logic [7:0]  mask;
  logic        cross_a;
  logic        bad_f3;
  logic        oor;
  logic        wrap;
  logic        err_a;
  logic [63:0] src;
  logic [31:0] res;
  logic [31:0] ext;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   nb = 3'd1;
      2'b01:   nb = 3'd2;
      default: nb = 3'd4;
    endcase
    span    = {1'b0, req_addr[1:0]} + nb;
    cross_a = span > 3'd4;
    mask    = (nb == 3'd1) ? 8'h01 : (nb == 3'd2) ? 8'h03 : 8'h0F;
    bad_f3  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_we && req_funct3[2]);
    oor     = |req_addr[31:ADDR_WIDTH+2];
    wrap    = cross_a && (&req_addr[ADDR_WIDTH+1:2]);
    err_a   = bad_f3 || oor || wrap || (cross_a && !MISALIGN_SPLIT);
  end

  // ACC1 merges the live high word with the low word captured in ACC0
  always_comb begin
    src = (state_q == ACC1) ? {mem_rdata, buf_q} : {32'b0, mem_rdata};
    res = 32'(src >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ext = {{24{res[7]}}, res[7:0]};
      3'b001:  ext = {{16{res[15]}}, res[15:0]};
      3'b100:  ext = {24'b0, res[7:0]};
      3'b101:  ext = {16'b0, res[15:0]};
      default: ext = res;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    f3_d        = f3_q;
    wa0_d       = wa0_q;
    cross_d     = cross_q;
    we_d        = we_q;
    be8_d       = be8_q;
    wd64_d      = wd64_q;
    buf_d       = buf_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready   = (state_q == IDLE);
    mem_we      = 1'b0;
    mem_be      = 4'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_op_read = 3'b010;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d   = req_addr[1:0];
          f3_d    = req_funct3;
          wa0_d   = req_addr[ADDR_WIDTH+1:2];
          cross_d = cross_a;
          we_d    = req_we;
          be8_d   = mask << req_addr[1:0];
          wd64_d  = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
          rdata_d = '0;
          err_d   = err_a;
          state_d = err_a ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_we    = we_q;
        mem_be    = be8_q[3:0];
        mem_addr  = wa0_q;
        mem_wdata = wd64_q[31:0];
        buf_d     = mem_rdata;
        if (cross_q) begin
          state_d = ACC1;
        end else begin
          state_d = RESP;
          rdata_d = we_q ? 32'b0 : ext;
        end
      end
      ACC1: begin
        mem_we    = we_q;
        mem_be    = be8_q[7:4];
        mem_addr  = wa0_q + ADDR_WIDTH'(1);
        mem_wdata = wd64_q[63:32];
        state_d   = RESP;
        rdata_d   = we_q ? 32'b0 : ext;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      f3_q    <= '0;
      wa0_q   <= '0;
      cross_q <= 1'b0;
      we_q    <= 1'b0;
      be8_q   <= '0;
      wd64_q  <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wa0_q   <= wa0_d;
      cross_q <= cross_d;
      we_q    <= we_d;
      be8_q   <= be8_d;
      wd64_q  <= wd64_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written
// multi-cycle sequences and random traffic against a byte-level model.
module tb_load_store_unit;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b0;
  logic [31:0]   req_addr = 32'b0;
  logic [31:0]   req_wdata = 32'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [2:0]    mem_op_read;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_be(mem_be), .mem_op_read(mem_op_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic          r1_req_valid = 1'b0;
  logic          r1_req_ready;
  logic          r1_req_we = 1'b0;
  logic [2:0]    r1_req_funct3 = 3'b010;
  logic [31:0]   r1_req_addr = 32'b0;
  logic [31:0]   r1_req_wdata = 32'b0;
  logic          r1_resp_valid;
  logic          r1_resp_ready = 1'b1;
  logic [31:0]   r1_resp_rdata;
  logic          r1_resp_err;
  logic          r1_mem_we;
  logic [3:0]    r1_mem_be;
  logic [2:0]    r1_mem_op_read;
  logic [AW-1:0] r1_mem_addr;
  logic [31:0]   r1_mem_wdata;
  logic [31:0]   r1_mem_rdata = 32'h12345678;

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MISALIGN_SPLIT(1'b0)) dut_nosplit (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_we(r1_req_we),
    .req_funct3(r1_req_funct3), .req_addr(r1_req_addr), .req_wdata(r1_req_wdata),
    .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready),
    .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err),
    .mem_we(r1_mem_we), .mem_be(r1_mem_be), .mem_op_read(r1_mem_op_read),
    .mem_addr(r1_mem_addr), .mem_wdata(r1_mem_wdata), .mem_rdata(r1_mem_rdata)
  );

  logic [31:0] mem [0:(1<<AW)-1];
  logic        mem_clr = 1'b1;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  logic [7:0] refm [0:131071];

  function automatic void ref_op(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er,
                                 output int lat);
    int n;
    int off;
    logic [31:0] v;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    er  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    if (a >= 32'h20000) er = 1'b1;
    if (!er && (off + n > 4) && (a / 4 == 32'h7FFF)) er = 1'b1;
    rd = '0;
    if (er) begin
      lat = 1;
      return;
    end
    lat = (off + n > 4) ? 3 : 2;
    if (we) begin
      for (int i = 0; i < n; i++) refm[17'(a + i)] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = refm[17'(a + i)];
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
      rd = v;
    end
  endfunction

  function automatic logic [31:0] ref_word(input int wa);
    return {refm[4*wa+3], refm[4*wa+2], refm[4*wa+1], refm[4*wa]};
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int            acc_cnt;
  logic [AW-1:0] acc_a [2];
  logic [3:0]    acc_be [2];
  logic [31:0]   acc_wd [2];
  logic          acc_we [2];

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cnt = 0; lat = 0; rd = '0; er = 1'b0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        rd = resp_rdata;
        er = resp_err;
        break;
      end
      if ((mem_be != 4'b0 || mem_we) && acc_cnt < 2) begin
        acc_a[acc_cnt] = mem_addr; acc_be[acc_cnt] = mem_be;
        acc_wd[acc_cnt] = mem_wdata; acc_we[acc_cnt] = mem_we;
        acc_cnt++;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, elat;
    int sel;
    logic we;
    logic [2:0] f3;
    logic [31:0] a, wd;

    tbl.push_back('{1'b1, 3'b010, 32'h100,     32'hA1B2C3D4, 32'h0,        1'b0, 2});
    tbl.push_back('{1'b0, 3'b000, 32'h103,     32'h0,        32'hFFFFFFA1, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b101, 32'h102,     32'h0,        32'h0000A1B2, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b100, 32'h101,     32'h0,        32'h000000C3, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b001, 32'h101,     32'h0,        32'hFFFFB2C3, 1'b0, 2});
    tbl.push_back('{1'b1, 3'b010, 32'h104,     32'h55667788, 32'h0,        1'b0, 2});
    tbl.push_back('{1'b0, 3'b010, 32'h102,     32'h0,        32'h7788A1B2, 1'b0, 3});
    tbl.push_back('{1'b0, 3'b001, 32'h103,     32'h0,        32'hFFFF88A1, 1'b0, 3});
    tbl.push_back('{1'b0, 3'b100, 32'h106,     32'h0,        32'h00000066, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b010, 32'h20000,   32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{1'b0, 3'b011, 32'h100,     32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{1'b0, 3'b010, 32'h1FFFE,   32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{1'b1, 3'b100, 32'h100,     32'hFF,       32'h0,        1'b1, 1});
    tbl.push_back('{1'b1, 3'b010, 32'h1FFFC,   32'hCAFEF00D, 32'h0,        1'b0, 2});
    tbl.push_back('{1'b0, 3'b010, 32'h1FFFC,   32'h0,        32'hCAFEF00D, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b001, 32'h1FFFF,   32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{1'b0, 3'b100, 32'h1FFFF,   32'h0,        32'h000000CA, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b110, 32'h100,     32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{1'b0, 3'b111, 32'h100,     32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{1'b1, 3'b000, 32'h102,     32'h123456FF, 32'h0,        1'b0, 2});
    tbl.push_back('{1'b0, 3'b010, 32'h100,     32'h0,        32'hA1FFC3D4, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b010, 32'h80000100, 32'h0,       32'h0,        1'b1, 1});

    for (int i = 0; i < 131072; i++) refm[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_op_read", 32'(mem_op_read), 32'd2);
    rst_n = 1'b1;
    mem_clr = 1'b0;

    foreach (tbl[i]) begin
      xact(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lat);
      ref_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, erd, eer, elat);
      chk($sformatf("tbl[%0d] rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl[%0d] err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("tbl[%0d] latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      if (tbl[i].exp_err) chk($sformatf("tbl[%0d] no mem access", i), 32'(acc_cnt), 32'd0);
      if (i == 0) begin
        chk("sw acc count", 32'(acc_cnt), 32'd1);
        chk("sw mem_addr", 32'(acc_a[0]), 32'h40);
        chk("sw mem_be", 32'(acc_be[0]), 32'hF);
        chk("sw mem_wdata", acc_wd[0], 32'hA1B2C3D4);
        chk("sw mem_we", 32'(acc_we[0]), 32'd1);
      end
      if (i == 6) begin
        chk("lw split acc0 addr", 32'(acc_a[0]), 32'h40);
        chk("lw split acc1 addr", 32'(acc_a[1]), 32'h41);
      end
    end

    xact(1'b1, 3'b001, 32'h103, 32'h0000BEEF, rd, er, lat);
    ref_op(1'b1, 3'b001, 32'h103, 32'h0000BEEF, erd, eer, elat);
    chk("sh split latency", 32'(lat), 32'd3);
    chk("sh split err", 32'(er), 32'd0);
    chk("sh split acc count", 32'(acc_cnt), 32'd2);
    chk("sh acc0 addr", 32'(acc_a[0]), 32'h40);
    chk("sh acc0 be", 32'(acc_be[0]), 32'h8);
    chk("sh acc0 wdata[31:24]", 32'(acc_wd[0][31:24]), 32'hEF);
    chk("sh acc1 addr", 32'(acc_a[1]), 32'h41);
    chk("sh acc1 be", 32'(acc_be[1]), 32'h1);
    chk("sh acc1 wdata[7:0]", 32'(acc_wd[1][7:0]), 32'hBE);
    xact(1'b0, 3'b010, 32'h104, 32'h0, rd, er, lat);
    chk("lw after sh", rd, 32'h556677BE);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h100; resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ref_op(1'b0, 3'b010, 32'h100, 32'h0, erd, eer, elat);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    chk("hold latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("hold[%0d] resp_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("hold[%0d] resp_rdata", k), resp_rdata, erd);
      chk($sformatf("hold[%0d] req_ready", k), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("release req_ready", 32'(req_ready), 32'd1);
    chk("release resp_valid", 32'(resp_valid), 32'd0);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h103; req_wdata = 32'h00005A34;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst-mid acc0 be", 32'(mem_be), 32'h8);
    rst_n = 1'b0;
    refm[32'h103] = 8'h34;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst-mid req_ready", 32'(req_ready), 32'd1);
    chk("rst-mid mem_we", 32'(mem_we), 32'd0);
    chk("rst-mid resp_valid", 32'(resp_valid), 32'd0);
    chk("rst-mid word 0x40", mem[15'h40], ref_word(32'h40));
    chk("rst-mid word 0x41", mem[15'h41], ref_word(32'h41));

    @(negedge clk);
    r1_req_valid = 1'b1; r1_req_funct3 = 3'b010; r1_req_addr = 32'h102;
    @(posedge clk);
    #1;
    r1_req_valid = 1'b0;
    @(negedge clk);
    chk("nosplit cross resp_valid", 32'(r1_resp_valid), 32'd1);
    chk("nosplit cross err", 32'(r1_resp_err), 32'd1);
    chk("nosplit cross mem_be", 32'(r1_mem_be), 32'd0);
    @(negedge clk);
    r1_req_valid = 1'b1; r1_req_addr = 32'h100;
    @(posedge clk);
    #1;
    r1_req_valid = 1'b0;
    @(negedge clk);
    chk("nosplit aligned addr", 32'(r1_mem_addr), 32'h40);
    @(negedge clk);
    chk("nosplit aligned resp_valid", 32'(r1_resp_valid), 32'd1);
    chk("nosplit aligned rdata", r1_resp_rdata, 32'h12345678);
    chk("nosplit aligned err", 32'(r1_resp_err), 32'd0);

    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 9));
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      wd  = $urandom;
      if (sel < 7)      a = 32'h100 + $urandom_range(0, 63);
      else if (sel < 9) a = 32'h1FFF0 + $urandom_range(0, 15);
      else              a = $urandom;
      ref_op(we, f3, a, wd, erd, eer, elat);
      xact(we, f3, a, wd, rd, er, lat);
      chk($sformatf("rnd[%0d] a=%h f3=%0d we=%0d rdata", it, a, f3, we), rd, erd);
      chk($sformatf("rnd[%0d] err", it), 32'(er), 32'(eer));
      chk($sformatf("rnd[%0d] latency", it), 32'(lat), 32'(elat));
      if (eer) chk($sformatf("rnd[%0d] no mem access", it), 32'(acc_cnt), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
